// File: rtl/clause_beat_packer_if.sv
// clause_beat_packer_if: controller-side write-beat and read-request/response bus of the clause beat packer.
// master = AXI memory controller side, slave = clause_beat_packer.
// Write: in_valid/in_ready/in_row/in_word/in_data/in_strb, flush_i, wr_err_o.
// Read:  rd_req_valid/rd_req_ready/rd_req_row/rd_req_word, rd_resp_valid/rd_resp_ready/rd_resp_data/rd_resp_err.
interface clause_beat_packer_if #(
  parameter int DATA_W     = 32,
  parameter int ROW_ADDR_W = 12,
  parameter int WIDX_W     = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ROW_ADDR_W-1:0] in_row;
  logic [WIDX_W-1:0]     in_word;
  logic [DATA_W-1:0]     in_data;
  logic [DATA_W/8-1:0]   in_strb;
  logic                  flush_i;
  logic                  wr_err_o;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ROW_ADDR_W-1:0] rd_req_row;
  logic [WIDX_W-1:0]     rd_req_word;
  logic                  rd_resp_valid;
  logic                  rd_resp_ready;
  logic [DATA_W-1:0]     rd_resp_data;
  logic                  rd_resp_err;
  modport master (
    output in_valid, in_row, in_word, in_data, in_strb, flush_i,
           rd_req_valid, rd_req_row, rd_req_word, rd_resp_ready,
    input  in_ready, wr_err_o, rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err
  );
  modport slave (
    input  in_valid, in_row, in_word, in_data, in_strb, flush_i,
           rd_req_valid, rd_req_row, rd_req_word, rd_resp_ready,
    output in_ready, wr_err_o, rd_req_ready, rd_resp_valid, rd_resp_data, rd_resp_err
  );
endinterface

// File: rtl/clause_beat_packer.sv
// clause_beat_packer: packs 32-bit beats into 480-bit clause rows and serves narrow reads from a row-wide table.
// Ports: clk, rst (async, active-low), bus (clause_beat_packer_if.slave: write beats, flush, read req/resp),
//        tbl_wr_en_o/tbl_wr_addr_o/tbl_wr_row_o (row write), tbl_rd_en_o/tbl_rd_addr_o/tbl_rd_row_i (row read, 1-cycle).
// Option: define CLAUSE_PACK_RMW_EN to seed each newly opened row from the table (read-modify-write).
module clause_beat_packer #(
  parameter int DATA_W     = 32,
  parameter int ROW_W      = 480,
  parameter int ROW_ADDR_W = 12,
  parameter int WORDS      = ROW_W / DATA_W,
  parameter int WIDX_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  clause_beat_packer_if.slave   bus,
  output logic                  tbl_wr_en_o,
  output logic [ROW_ADDR_W-1:0] tbl_wr_addr_o,
  output logic [ROW_W-1:0]      tbl_wr_row_o,
  output logic                  tbl_rd_en_o,
  output logic [ROW_ADDR_W-1:0] tbl_rd_addr_o,
  input  logic [ROW_W-1:0]      tbl_rd_row_i
);
  localparam int SW = DATA_W / 8;
  localparam logic [WIDX_W-1:0] LAST = WIDX_W'(WORDS - 1);
`ifdef CLAUSE_PACK_RMW_EN
  typedef enum logic [1:0] {IDLE, FILL, COMMIT, FETCH} wst_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, COMMIT} wst_t;
`endif
  typedef enum logic [1:0] {RIDLE, RWAIT, RRESP} rd_st_t;
  wst_t                  wst;
  rd_st_t                rd_st;
  logic [ROW_ADDR_W-1:0] open_row;
  logic [ROW_W-1:0]      shadow;
  logic [WORDS-1:0]      mask;
  logic [ROW_ADDR_W-1:0] rd_row;
  logic [WIDX_W-1:0]     rd_word;
  logic                  in_bad, in_acc, in_good, diff_row, rd_bad, rd_acc, fetch_busy, fwd;
  logic [ROW_W-1:0]      merged;
  logic [WORDS-1:0]      nmask;
`ifdef CLAUSE_PACK_RMW_EN
  logic [WIDX_W-1:0]     p_word;
  logic [DATA_W-1:0]     p_data;
  logic [SW-1:0]         p_strb;
`endif

  function automatic logic [ROW_W-1:0] merge(input logic [ROW_W-1:0] r, input logic [WIDX_W-1:0] w,
                                             input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
    logic [ROW_W-1:0] o;
    o = r;
    for (int b = 0; b < SW; b++)
      if (s[b]) o[int'(w) * DATA_W + b * 8 +: 8] = d[b * 8 +: 8];
    return o;
  endfunction

  always_comb begin
    in_bad       = bus.in_word > LAST;
    diff_row     = bus.in_valid && !in_bad && bus.in_row != open_row;
    // A beat for another row stalls until the open row has been committed.
    bus.in_ready = wst == IDLE || (wst == FILL && !diff_row);
    in_acc       = bus.in_valid && bus.in_ready;
    in_good      = in_acc && !in_bad;
    merged       = merge(wst == FILL ? shadow : '0, bus.in_word, bus.in_data, bus.in_strb);
    nmask        = (wst == FILL ? mask : '0) | (WORDS'(1) << bus.in_word);
    rd_bad       = bus.rd_req_word > LAST;
`ifdef CLAUSE_PACK_RMW_EN
    // The row fetch owns the read port in the opening cycle and while waiting for its data.
    fetch_busy   = wst == FETCH || (wst == IDLE && in_good);
`else
    fetch_busy   = 1'b0;
`endif
    bus.rd_req_ready = rd_st == RIDLE && !fetch_busy;
    rd_acc        = bus.rd_req_valid && bus.rd_req_ready;
    tbl_rd_en_o   = rd_acc && !rd_bad;
    tbl_rd_addr_o = tbl_rd_en_o ? bus.rd_req_row : '0;
`ifdef CLAUSE_PACK_RMW_EN
    if (wst == IDLE && in_good) begin
      tbl_rd_en_o   = 1'b1;
      tbl_rd_addr_o = bus.in_row;
    end
`endif
    tbl_wr_en_o   = wst == COMMIT;
    tbl_wr_addr_o = open_row;
    tbl_wr_row_o  = shadow;
    // Mask and open_row survive the commit, so the shadow keeps serving the same data as the table.
    fwd = rd_row == open_row && mask[rd_word];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wst          <= IDLE;
      open_row     <= '0;
      shadow       <= '0;
      mask         <= '0;
      bus.wr_err_o <= 1'b0;
`ifdef CLAUSE_PACK_RMW_EN
      p_word       <= '0;
      p_data       <= '0;
      p_strb       <= '0;
`endif
    end else begin
      bus.wr_err_o <= in_acc && in_bad;
      case (wst)
        IDLE: if (in_good) begin
          open_row <= bus.in_row;
`ifdef CLAUSE_PACK_RMW_EN
          mask     <= '0;
          p_word   <= bus.in_word;
          p_data   <= bus.in_data;
          p_strb   <= bus.in_strb;
          wst      <= FETCH;
`else
          shadow   <= merged;
          mask     <= nmask;
          wst      <= &nmask ? COMMIT : FILL;
`endif
        end
        FILL: begin
          if (in_good) begin
            shadow <= merged;
            mask   <= nmask;
          end
          if (bus.flush_i || diff_row || (in_good && &nmask)) wst <= COMMIT;
        end
`ifdef CLAUSE_PACK_RMW_EN
        FETCH: begin
          shadow <= merge(tbl_rd_row_i, p_word, p_data, p_strb);
          mask   <= WORDS'(1) << p_word;
          wst    <= &(WORDS'(1) << p_word) ? COMMIT : FILL;
        end
`endif
        default: wst <= IDLE;
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_st             <= RIDLE;
      rd_row            <= '0;
      rd_word           <= '0;
      bus.rd_resp_valid <= 1'b0;
      bus.rd_resp_data  <= '0;
      bus.rd_resp_err   <= 1'b0;
    end else
      case (rd_st)
        RIDLE: if (rd_acc) begin
          rd_row  <= bus.rd_req_row;
          rd_word <= bus.rd_req_word;
          if (rd_bad) begin
            bus.rd_resp_valid <= 1'b1;
            bus.rd_resp_err   <= 1'b1;
            bus.rd_resp_data  <= '0;
            rd_st             <= RRESP;
          end else rd_st <= RWAIT;
        end
        RWAIT: begin
          bus.rd_resp_valid <= 1'b1;
          bus.rd_resp_err   <= 1'b0;
          bus.rd_resp_data  <= fwd ? shadow[int'(rd_word) * DATA_W +: DATA_W]
                                   : tbl_rd_row_i[int'(rd_word) * DATA_W +: DATA_W];
          rd_st             <= RRESP;
        end
        RRESP: if (bus.rd_resp_ready) begin
          bus.rd_resp_valid <= 1'b0;
          rd_st             <= RIDLE;
        end
        default: rd_st <= RIDLE;
      endcase
endmodule

// File: tb/tb_clause_beat_packer.sv
// tb_clause_beat_packer: directed self-checking bench for clause_beat_packer with a row-wide table model.
module tb_clause_beat_packer;
  localparam int DW = 32, RW = 480, AW = 12, XW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic          tbl_wr_en_o, tbl_rd_en_o;
  logic [AW-1:0] tbl_wr_addr_o, tbl_rd_addr_o;
  logic [RW-1:0] tbl_wr_row_o;
  logic [RW-1:0] tbl_rd_row_i = '0;
  logic [RW-1:0] mem [0:(1<<AW)-1];
  logic [RW-1:0] exp_row;
  int wr_cnt = 0;
  int n_vec = 0;
  int n_bad = 0;

  clause_beat_packer_if #(.DATA_W(DW), .ROW_ADDR_W(AW), .WIDX_W(XW)) bus ();

  clause_beat_packer dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .tbl_wr_en_o(tbl_wr_en_o), .tbl_wr_addr_o(tbl_wr_addr_o), .tbl_wr_row_o(tbl_wr_row_o),
    .tbl_rd_en_o(tbl_rd_en_o), .tbl_rd_addr_o(tbl_rd_addr_o), .tbl_rd_row_i(tbl_rd_row_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_wr_en_o) begin
      mem[tbl_wr_addr_o] <= tbl_wr_row_o;
      wr_cnt <= wr_cnt + 1;
    end
    if (tbl_rd_en_o) tbl_rd_row_i <= mem[tbl_rd_addr_o];
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] r, input logic [XW-1:0] w, input logic [DW-1:0] d, input logic [3:0] s);
    bus.in_valid = 1'b1;
    bus.in_row   = r;
    bus.in_word  = w;
    bus.in_data  = d;
    bus.in_strb  = s;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush_i  = 1'b0;
  endtask

  function automatic logic [RW-1:0] one_word(input int w, input logic [DW-1:0] d);
    logic [RW-1:0] r;
    r = '0;
    r[w*DW +: DW] = d;
    return r;
  endfunction

  task automatic do_read(input string tag, input logic [AW-1:0] r, input logic [XW-1:0] w, input logic [DW-1:0] d);
    bus.rd_req_valid  = 1'b1;
    bus.rd_req_row    = r;
    bus.rd_req_word   = w;
    bus.rd_resp_ready = 1'b1;
    step();
    bus.rd_req_valid = 1'b0;
    step();
    check({tag, "_valid"}, bus.rd_resp_valid, 1);
    check({tag, "_data"}, bus.rd_resp_data, d);
    step();
  endtask

  initial begin
    bus.in_valid = 0; bus.in_row = 0; bus.in_word = 0; bus.in_data = 0; bus.in_strb = 0; bus.flush_i = 0;
    bus.rd_req_valid = 0; bus.rd_req_row = 0; bus.rd_req_word = 0; bus.rd_resp_ready = 0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_rd_req_ready", bus.rd_req_ready, 1);
    check("rst_wr_en", tbl_wr_en_o, 0);
    check("rst_resp_valid", bus.rd_resp_valid, 0);
    check("rst_wr_err", bus.wr_err_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // full row of 15 beats commits on its own
    exp_row = '0;
    for (int w = 0; w < 15; w++) begin
      beat(12'd5, 4'(w), 32'hC000_0000 + 32'(w), 4'hF);
      exp_row[w*DW +: DW] = 32'hC000_0000 + 32'(w);
      step();
    end
    idle();
    check("t1_wr_en", tbl_wr_en_o, 1);
    check("t1_wr_addr", tbl_wr_addr_o, 5);
    check("t1_wr_row", tbl_wr_row_o, exp_row);
    check("t1_in_ready_commit", bus.in_ready, 0);
    step();
    check("t1_wr_en_once", tbl_wr_en_o, 0);
    check("t1_wr_cnt", wr_cnt, 1);

    // byte-strobed overwrite merged together with a flush
    beat(12'd3, 4'd2, 32'hDEAD_BEEF, 4'hF);
    step();
    beat(12'd3, 4'd2, 32'h1111_2222, 4'b0011);
    bus.flush_i = 1'b1;
    step();
    idle();
    check("t2_wr_en", tbl_wr_en_o, 1);
    check("t2_wr_addr", tbl_wr_addr_o, 3);
    check("t2_wr_row", tbl_wr_row_o, one_word(2, 32'hDEAD_2222));
    step();

    // beat to another row forces a commit first
    beat(12'd7, 4'd0, 32'hA0A0_0000, 4'hF);
    step();
    beat(12'd7, 4'd1, 32'hA1A1_0001, 4'hF);
    step();
    beat(12'd8, 4'd3, 32'hB3B3_0003, 4'hF);
    #1 check("t3_ready_blocked", bus.in_ready, 0);
    step();
    check("t3_wr_en", tbl_wr_en_o, 1);
    check("t3_wr_addr", tbl_wr_addr_o, 7);
    check("t3_wr_row", tbl_wr_row_o, one_word(0, 32'hA0A0_0000) | one_word(1, 32'hA1A1_0001));
    step();
    check("t3_ready_reopen", bus.in_ready, 1);
    step();
    idle();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("t3_row8_addr", tbl_wr_addr_o, 8);
    check("t3_row8_row", tbl_wr_row_o, one_word(3, 32'hB3B3_0003));
    step();
    check("t3_wr_cnt", wr_cnt, 4);

    // out-of-range word on write and read
    beat(12'd4, 4'd1, 32'h4444_0001, 4'hF);
    step();
    beat(12'd4, 4'd15, 32'hFFFF_FFFF, 4'hF);
    #1 check("t4_bad_ready", bus.in_ready, 1);
    step();
    idle();
    check("t4_wr_err", bus.wr_err_o, 1);
    check("t4_no_wr_en", tbl_wr_en_o, 0);
    step();
    check("t4_wr_err_pulse", bus.wr_err_o, 0);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    check("t4_wr_en", tbl_wr_en_o, 1);
    check("t4_wr_row", tbl_wr_row_o, one_word(1, 32'h4444_0001));
    step();
    bus.rd_req_valid = 1'b1; bus.rd_req_row = 12'd4; bus.rd_req_word = 4'd15; bus.rd_resp_ready = 1'b0;
    #1 check("t4_no_rd_en", tbl_rd_en_o, 0);
    step();
    bus.rd_req_valid = 1'b0;
    check("t4_err_valid", bus.rd_resp_valid, 1);
    check("t4_err_flag", bus.rd_resp_err, 1);
    check("t4_err_data", bus.rd_resp_data, 0);
    bus.rd_resp_ready = 1'b1;
    step();
    check("t4_err_done", bus.rd_resp_valid, 0);

    // forwarding from the open shadow, held response under back-pressure
    beat(12'd9, 4'd5, 32'h5555_5555, 4'hF);
    step();
    idle();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    beat(12'd9, 4'd4, 32'h9999_0004, 4'hF);
    step();
    idle();
    bus.rd_req_valid = 1'b1; bus.rd_req_row = 12'd9; bus.rd_req_word = 4'd4; bus.rd_resp_ready = 1'b0;
    #1 check("t5_rd_en", tbl_rd_en_o, 1);
    check("t5_rd_addr", tbl_rd_addr_o, 9);
    step();
    bus.rd_req_valid = 1'b0;
    check("t5_n1_valid", bus.rd_resp_valid, 0);
    check("t5_n1_req_ready", bus.rd_req_ready, 0);
    step();
    check("t5_n2_valid", bus.rd_resp_valid, 1);
    check("t5_n2_data", bus.rd_resp_data, 32'h9999_0004);
    check("t5_n2_err", bus.rd_resp_err, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_valid", bus.rd_resp_valid, 1);
      check("t5_hold_data", bus.rd_resp_data, 32'h9999_0004);
    end
    bus.rd_resp_ready = 1'b1;
    step();
    check("t5_done", bus.rd_resp_valid, 0);
    do_read("t5_tbl_w5", 12'd9, 4'd5, 32'h5555_5555);
    do_read("t5_tbl_r7", 12'd7, 4'd1, 32'hA1A1_0001);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    step();
    check("t5_wr_cnt", wr_cnt, 7);

    // reset in the middle of a fill with a response pending
    for (int w = 0; w < 3; w++) begin
      beat(12'd2, 4'(w), 32'h2222_0000 + 32'(w), 4'hF);
      step();
    end
    idle();
    bus.rd_req_valid = 1'b1; bus.rd_req_row = 12'd7; bus.rd_req_word = 4'd0; bus.rd_resp_ready = 1'b0;
    step();
    bus.rd_req_valid = 1'b0;
    step();
    check("t6_pending", bus.rd_resp_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_wr_en", tbl_wr_en_o, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_rd_req_ready", bus.rd_req_ready, 1);
    check("t6_resp_valid", bus.rd_resp_valid, 0);
    check("t6_wr_addr", tbl_wr_addr_o, 0);
    check("t6_wr_row", tbl_wr_row_o, 0);
    bus.rd_resp_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    bus.flush_i = 1'b1;
    step();
    step();
    bus.flush_i = 1'b0;
    check("t6_no_commit_en", tbl_wr_en_o, 0);
    check("t6_wr_cnt", wr_cnt, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
